noc_input_buffer: RTL and testbench

- Receiving end of the router's ReqAck link.
- Accepts flits from an upstream router's output multiplexer and stores them in a small FIFO.
- Computes an XY route for each packet's head flit and holds a one-hot route request to the switch arbiter until the packet's tail flit leaves.
- One instance per input port (local, west, north, east, south); it feeds the per-output-port switch multiplexers.

---
 rtl/noc_pkg.sv | 49 ++++
 rtl/noc_sync_fifo.sv | 53 +++++
 rtl/noc_input_buffer.sv | 143 ++++++++++++++
 tb/tb_noc_input_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC types: flit type codes, port indices, router FSM
//               states and the XY routing function.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  typedef logic [1:0] flit_type_t;

  localparam flit_type_t FLIT_HEAD      = 2'b10;
  localparam flit_type_t FLIT_BODY      = 2'b00;
  localparam flit_type_t FLIT_TAIL      = 2'b01;
  localparam flit_type_t FLIT_HEAD_TAIL = 2'b11;

  localparam int unsigned PORT_LOCAL = 0;
  localparam int unsigned PORT_WEST  = 1;
  localparam int unsigned PORT_NORTH = 2;
  localparam int unsigned PORT_EAST  = 3;
  localparam int unsigned PORT_SOUTH = 4;
  localparam int unsigned NUM_PORTS  = 5;

  // Widest coordinate that fits twice into a 16-bit head payload.
  localparam int unsigned MAX_COORD_W = 8;
  typedef logic [MAX_COORD_W-1:0] coord_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ROUTED = 1'b1
  } buf_state_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [NUM_PORTS-1:0] xy_route(input coord_t dst_x,
                                                    input coord_t dst_y,
                                                    input coord_t x_id,
                                                    input coord_t y_id);
    logic [NUM_PORTS-1:0] r;
    r = '0;
    if (dst_x > x_id)      r[PORT_EAST]  = 1'b1;
    else if (dst_x < x_id) r[PORT_WEST]  = 1'b1;
    else if (dst_y > y_id) r[PORT_NORTH] = 1'b1;
    else if (dst_y < y_id) r[PORT_SOUTH] = 1'b1;
    else                   r[PORT_LOCAL] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_sync_fifo
// Description : Synchronous FIFO with extra-MSB pointers, registered head.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] c_ptr_one = 1;

  logic [AW:0]           wptr_q;
  logic [AW:0]           rptr_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  w_push;
  logic                  w_pop;

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + c_ptr_one;
      if (w_pop)  rptr_q <= rptr_q + c_ptr_one;
    end
  end

  // Storage needs no reset: empty pointers hide stale contents.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/noc_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : noc_input_buffer
// Description : Router input port: flit FIFO, XY route computation and
//               per-packet route request. Optional statistics counters are
//               enabled by defining NOC_INPUT_BUFFER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned X_ID       = 0,
  parameter int unsigned Y_ID       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_req,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ack,
  output logic                  out_req,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ack,
  output logic [4:0]            route_req
`ifdef NOC_INPUT_BUFFER_STATS_EN
  ,
  output logic [15:0]           flit_cnt,
  output logic [7:0]            drop_cnt
`endif
);

  localparam logic [COORD_W-1:0] c_x_id = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] c_y_id = COORD_W'(Y_ID);

  buf_state_t            state_q, state_d;
  logic [4:0]            route_q, route_d;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  flit_type_t            w_head_type;
  logic                  w_is_head;
  logic                  w_is_tail;
  logic [COORD_W-1:0]    w_dst_x;
  logic [COORD_W-1:0]    w_dst_y;

  // Acceptance depends on registered occupancy only, never on out_ack.
  assign in_ack = !w_full && !rst;
  assign w_push = in_req && in_ack;

  noc_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (in_data),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_head_type = w_head[DATA_WIDTH-1 -: 2];
  assign w_is_head   = w_head_type[1];
  assign w_is_tail   = w_head_type[0];
  assign w_dst_x     = w_head[2*COORD_W-1 -: COORD_W];
  assign w_dst_y     = w_head[COORD_W-1:0];
  assign out_data    = w_head;
  assign route_req   = route_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    out_req = 1'b0;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          if (w_is_head) begin
            route_d = xy_route(coord_t'(w_dst_x), coord_t'(w_dst_y),
                               coord_t'(c_x_id), coord_t'(c_y_id));
            state_d = ST_ROUTED;
          end else begin
            // Body/tail without a preceding head cannot be routed.
            w_pop = 1'b1;
          end
        end
      end
      ST_ROUTED: begin
        out_req = !w_empty;
        if (out_req && out_ack) begin
          w_pop = 1'b1;
          if (w_is_tail) begin
            route_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        route_d = '0;
      end
    endcase
  end

`ifdef NOC_INPUT_BUFFER_STATS_EN
  logic [15:0] flit_cnt_q;
  logic [7:0]  drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (w_pop && (state_q == ST_ROUTED)) flit_cnt_q <= flit_cnt_q + 16'd1;
      if (w_pop && (state_q == ST_IDLE) && (drop_cnt_q != 8'hFF))
        drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign flit_cnt = flit_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  // Statistics counters are not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_input_buffer
// Description : Self-checking bench for noc_input_buffer at router (1,1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_input_buffer;

  localparam int unsigned DW    = 18;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          in_req;
  logic [DW-1:0] in_data;
  logic          in_ack;
  logic          out_req;
  logic [DW-1:0] out_data;
  logic          out_ack;
  logic [4:0]    route_req;
`ifdef NOC_INPUT_BUFFER_STATS_EN
  logic [15:0]   flit_cnt;
  logic [7:0]    drop_cnt;
`endif

  noc_input_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .COORD_W    (4),
    .X_ID       (1),
    .Y_ID       (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_req   (out_req),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .route_req (route_req)
`ifdef NOC_INPUT_BUFFER_STATS_EN
    ,
    .flit_cnt  (flit_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb[$];
  bit            sb_push_en = 1'b1;
  bit            chk_ack = 1'b0;
  int            m_cnt = 0;
  int            n_out = 0;
  bit            last_acc = 1'b0;

  typedef struct {
    logic [3:0] dx;
    logic [3:0] dy;
    logic [4:0] route;
  } rvec_t;

  rvec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [15:0] p);
    return {t, p};
  endfunction

  // One clock: drive inputs, observe handshakes mid-cycle, return 1ns after the edge.
  task automatic cycle(input logic req, input logic [DW-1:0] d, input logic ack);
    logic [DW-1:0] exp;
    in_req  = req;
    in_data = d;
    out_ack = ack;
    @(negedge clk);
    if (chk_ack) check("in_ack_vs_occupancy", {31'd0, in_ack}, {31'd0, (m_cnt < DEPTH)});
    if (out_req && out_ack) begin
      n_out++;
      m_cnt--;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h expected=none", out_data);
      end else begin
        exp = sb.pop_front();
        check("out_data", {14'd0, out_data}, {14'd0, exp});
      end
    end
    last_acc = in_req && in_ack;
    if (last_acc) begin
      m_cnt++;
      if (sb_push_en) sb.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) cycle(1'b0, '0, 1'b1);
    check("drain_remaining", sb.size(), 0);
  endtask

  int            phase;
  logic [DW-1:0] pend_d;
  bit            pend;
  bit            req;
  int            seq;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'd1, 4'd1, 5'b00001};
    vt[1] = '{4'd0, 4'd1, 5'b00010};
    vt[2] = '{4'd1, 4'd2, 5'b00100};
    vt[3] = '{4'd3, 4'd1, 5'b01000};
    vt[4] = '{4'd1, 4'd0, 5'b10000};
    vt[5] = '{4'd2, 4'd0, 5'b01000};
    vt[6] = '{4'd0, 4'd3, 5'b00010};
    vt[7] = '{4'd1, 4'd15, 5'b00100};
    vt[8] = '{4'd15, 4'd15, 5'b01000};

    rst = 1'b1; in_req = 1'b0; in_data = '0; out_ack = 1'b0;
    repeat (3) cycle(1'b0, '0, 1'b0);
    check("reset_in_ack", {31'd0, in_ack}, 0);
    check("reset_out_req", {31'd0, out_req}, 0);
    check("reset_route", {27'd0, route_req}, 0);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0);
    check("post_reset_in_ack", {31'd0, in_ack}, 1);
    check("post_reset_out_req", {31'd0, out_req}, 0);
`ifdef NOC_INPUT_BUFFER_STATS_EN
    check("reset_flit_cnt", {16'd0, flit_cnt}, 0);
    check("reset_drop_cnt", {24'd0, drop_cnt}, 0);
`endif

    // Routing table: single-flit packets to every direction.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, mk(2'b11, {8'(i), vt[i].dx, vt[i].dy}), 1'b0);
      check("pre_route_out_req", {31'd0, out_req}, 0);
      check("pre_route_route", {27'd0, route_req}, 0);
      cycle(1'b0, '0, 1'b0);
      check("route_req", {27'd0, route_req}, {27'd0, vt[i].route});
      check("routed_out_req", {31'd0, out_req}, 1);
      cycle(1'b0, '0, 1'b1);
      check("after_tail_route", {27'd0, route_req}, 0);
      check("after_tail_out_req", {31'd0, out_req}, 0);
    end

    // 4-flit packet fills the FIFO; a full FIFO refuses even while popping.
    cycle(1'b1, mk(2'b10, 16'h0031), 1'b0);
    cycle(1'b1, mk(2'b00, 16'hB001), 1'b0);
    cycle(1'b1, mk(2'b00, 16'hB002), 1'b0);
    cycle(1'b1, mk(2'b01, 16'hD003), 1'b0);
    check("full_in_ack", {31'd0, in_ack}, 0);
    check("full_route", {27'd0, route_req}, 5'b01000);
    check("full_out_req", {31'd0, out_req}, 1);
    cycle(1'b1, mk(2'b11, 16'hEE11), 1'b1);
    check("full_no_accept", {31'd0, last_acc}, 0);
    drain(10);
    check("pkt_route_cleared", {27'd0, route_req}, 0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("no_ghost_flit", {31'd0, out_req}, 0);

    // Back-to-back packets: route drops to 0 between them.
    phase = 0;
    cycle(1'b1, mk(2'b10, 16'h0031), 1'b1);
    cycle(1'b1, mk(2'b01, 16'h7001), 1'b1);
    cycle(1'b1, mk(2'b11, 16'h0110), 1'b1);
    for (int i = 0; i < 12; i++) begin
      case (phase)
        0: if (route_req == 5'b01000) phase = 1;
        1: if (route_req == 5'b00000) phase = 2;
        2: if (route_req == 5'b10000) phase = 3;
        default: ;
      endcase
      cycle(1'b0, '0, 1'b1);
    end
    check("b2b_route_sequence", phase, 3);
    check("b2b_drained", sb.size(), 0);

    // Orphan body and tail flits are dropped in IDLE.
    sb_push_en = 1'b0;
    cycle(1'b1, mk(2'b00, 16'h1234), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1);
      check("drop_out_req", {31'd0, out_req}, 0);
    end
    check("drop_route", {27'd0, route_req}, 0);
`ifdef NOC_INPUT_BUFFER_STATS_EN
    check("drop_cnt_1", {24'd0, drop_cnt}, 1);
`endif
    cycle(1'b1, mk(2'b01, 16'h5678), 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("drop_tail_out_req", {31'd0, out_req}, 0);
`ifdef NOC_INPUT_BUFFER_STATS_EN
    check("drop_cnt_2", {24'd0, drop_cnt}, 2);
`endif
    sb_push_en = 1'b1;

    // Random concurrent push/pop with the FIFO primed to two flits.
    m_cnt = 0;
    chk_ack = 1'b1;
    cycle(1'b1, mk(2'b10, 16'h0021), 1'b0);
    cycle(1'b1, mk(2'b00, 16'h0000), 1'b0);
    pend = 1'b0;
    seq = 1;
    for (int i = 0; i < 20; i++) begin
      if (!pend) begin
        req = 1'($urandom_range(0, 1));
        pend_d = mk(2'b00, 16'(seq));
        if (req) seq++;
      end
      cycle(req, pend_d, 1'($urandom_range(0, 1)));
      pend = req && !last_acc;
    end
    for (int i = 0; i < 10; i++) begin
      if (pend) begin
        cycle(1'b1, pend_d, 1'b1);
        pend = !last_acc;
      end else begin
        cycle(1'b1, mk(2'b01, 16'hFFFF), 1'b1);
        if (last_acc) break;
      end
    end
    drain(12);
    check("rand_route_cleared", {27'd0, route_req}, 0);
    chk_ack = 1'b0;

    // Reset in the middle of a packet discards it.
    cycle(1'b1, mk(2'b10, 16'h0031), 1'b0);
    cycle(1'b1, mk(2'b00, 16'hAAAA), 1'b0);
    check("pre_reset_route", {27'd0, route_req}, 5'b01000);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0);
    check("midrst_out_req", {31'd0, out_req}, 0);
    check("midrst_route", {27'd0, route_req}, 0);
    check("midrst_in_ack", {31'd0, in_ack}, 0);
    rst = 1'b0;
    sb.delete();
    n_out = 0;
    cycle(1'b0, '0, 1'b1);
    check("postrst_empty", {31'd0, out_req}, 0);
    cycle(1'b1, mk(2'b11, 16'h0911), 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("postrst_route", {27'd0, route_req}, 5'b00001);
    drain(4);
    check("postrst_route_cleared", {27'd0, route_req}, 0);
`ifdef NOC_INPUT_BUFFER_STATS_EN
    check("flit_cnt", {16'd0, flit_cnt}, n_out);
    check("drop_cnt_after_rst", {24'd0, drop_cnt}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
